// File: rtl/sw_out_port_ctrl_pkg.sv
// rtl/sw_out_port_ctrl_pkg.sv - shared state encodings, defaults and width helper for the output-port controller
package sw_out_port_ctrl_pkg;

    typedef enum logic {
        SW_IDLE = 1'b0,
        SW_BUSY = 1'b1
    } sw_state_t;

    localparam int DEF_IN_NUM    = 4;
    localparam int DEF_BUF_DEPTH = 4;

    // Never return zero so a degenerate single-input port still gets a 1-bit select.
    function automatic int log2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or above ptr, with wrap
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  request,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [SW-1:0] idx
);

    logic          found;
    logic [SW-1:0] cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i >= N) ? SW'(int'(ptr) + i - N) : SW'(int'(ptr) + i);
            if (!found && request[cand]) begin
                found       = 1'b1;
                idx         = cand;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_out_port_ctrl.sv
// rtl/sw_out_port_ctrl.sv - per-output-port packet arbiter with crossbar select and downstream credit tracking
module sw_out_port_ctrl
    import sw_out_port_ctrl_pkg::*;
#(
    parameter int IN_NUM    = DEF_IN_NUM,
    parameter int SEL_WIDTH = log2_min1(IN_NUM),
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int CNT_WIDTH = log2_min1(BUF_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_NUM-1:0]    request,
    input  logic [IN_NUM-1:0]    tail_in,
    input  logic                 credit_in,
    output logic [IN_NUM-1:0]    grant,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 flit_wr,
    output logic [IN_NUM-1:0]    flit_ack,
    output logic [CNT_WIDTH-1:0] credit_cnt
);

    sw_state_t            state, state_nxt;
    logic [SEL_WIDTH-1:0] ptr;
    logic [IN_NUM-1:0]    arb_winner;
    logic [SEL_WIDTH-1:0] arb_idx;
    logic                 pkt_done;

    rr_arbiter #(
        .N  (IN_NUM),
        .SW (SEL_WIDTH)
    ) u_arb (
        .request (request),
        .ptr     (ptr),
        .winner  (arb_winner),
        .idx     (arb_idx)
    );

    assign pkt_done = flit_wr && tail_in[sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SW_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SW_IDLE: if (|request) state_nxt = SW_BUSY;
            SW_BUSY: if (pkt_done)  state_nxt = SW_IDLE;
            default: state_nxt = SW_IDLE;
        endcase
    end

    always_comb begin
        flit_wr  = 1'b0;
        flit_ack = '0;
        if (state == SW_BUSY && request[sel] && credit_cnt != '0) begin
            flit_wr  = 1'b1;
            flit_ack = grant;
        end
    end

    // sel deliberately keeps its last value after a tail so the mux stays quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant <= '0;
            sel   <= '0;
            ptr   <= '0;
        end else if (state == SW_IDLE && |request) begin
            grant <= arb_winner;
            sel   <= arb_idx;
        end else if (pkt_done) begin
            grant <= '0;
            ptr   <= (sel == SEL_WIDTH'(IN_NUM - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_cnt <= CNT_WIDTH'(BUF_DEPTH);
        end else if (flit_wr && !credit_in) begin
            credit_cnt <= credit_cnt - 1'b1;
        end else if (credit_in && !flit_wr && credit_cnt != CNT_WIDTH'(BUF_DEPTH)) begin
            credit_cnt <= credit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sw_out_port_ctrl.sv
// tb/tb_sw_out_port_ctrl.sv - directed scoreboard bench for sw_out_port_ctrl
module tb_sw_out_port_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] request = '0;
    logic [3:0] tail_in = '0;
    logic       credit_in = 1'b0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       flit_wr;
    logic [3:0] flit_ack;
    logic [2:0] credit_cnt;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int exp_q[$];
    int rem[4];
    int plen[4];
    int pos[4];

    sw_out_port_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .request    (request),
        .tail_in    (tail_in),
        .credit_in  (credit_in),
        .grant      (grant),
        .sel        (sel),
        .flit_wr    (flit_wr),
        .flit_ack   (flit_ack),
        .credit_cnt (credit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            request[i] = (rem[i] > 0);
            tail_in[i] = (rem[i] > 0) && (pos[i] == plen[i] - 1);
        end
    endtask

    task automatic load(input int i, input int len, input int npk);
        rem[i]  = len * npk;
        plen[i] = len;
        pos[i]  = 0;
        drive_inputs();
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0; plen[i] = 1; pos[i] = 0;
        end
        drive_inputs();
    endtask

    task automatic push(input int i, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(i);
    endtask

    // Requesters pop a flit on the edge that samples its ack.
    task automatic tick(input logic c);
        logic [3:0] ack;
        credit_in = c;
        ack = flit_ack;
        @(posedge clk);
        #1;
        credit_in = 1'b0;
        if (reset === 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (ack[i] && rem[i] > 0) begin
                    rem[i]--;
                    pos[i] = (pos[i] + 1 == plen[i]) ? 0 : pos[i] + 1;
                end
            end
        end
        drive_inputs();
        #1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && flit_wr === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_flit", 32'(sel), 32'hFFFF);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("flit_sel", 32'(sel), 32'(e));
                chk("flit_ack", 32'(flit_ack), 32'(4'b0001 << e));
            end
        end
    end

    initial begin
        clear_all();
        reset = 1'b1;
        tick(0);
        tick(0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_flit_wr", 32'(flit_wr), 0);
        chk("rst_credit", 32'(credit_cnt), 4);
        reset = 1'b0;
        tick(0);
        chk("idle_no_req_grant", 32'(grant), 0);

        // single 3-flit packet from requester 2
        wr_count = 0;
        load(2, 3, 1); push(2, 3);
        tick(0);
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_sel", 32'(sel), 2);
        chk("single_flit_wr", 32'(flit_wr), 1);
        tick(0); tick(0); tick(0);
        chk("single_done_grant", 32'(grant), 0);
        chk("single_done_sel_hold", 32'(sel), 2);
        chk("single_wr_count", 32'(wr_count), 3);
        chk("single_credit", 32'(credit_cnt), 1);
        tick(1); tick(1); tick(1);
        chk("credit_refill", 32'(credit_cnt), 4);

        // ptr should now be 3: requesters 1 and 3 race, 3 wins
        load(1, 1, 1); load(3, 1, 1); push(3, 1); push(1, 1);
        tick(0);
        chk("ptr3_grant", 32'(grant), 32'h8);
        tick(1); tick(1); tick(1);
        chk("ptr3_credit_sat", 32'(credit_cnt), 4);

        reset = 1'b1; tick(0); reset = 1'b0;

        // fairness with continuous single-flit packets
        wr_count = 0;
        load(0, 1, 2); load(1, 1, 2); load(2, 1, 1); load(3, 1, 1);
        push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(0, 1); push(1, 1);
        for (int k = 0; k < 12; k++) tick(1);
        chk("fair_wr_count", 32'(wr_count), 6);
        chk("fair_q_empty", 32'(exp_q.size()), 0);

        // 5-flit packet is not preempted by a later request
        load(2, 5, 1); push(2, 5);
        tick(1);
        chk("nopre_grant", 32'(grant), 32'h4);
        tick(1);
        load(0, 1, 1); push(0, 1);
        tick(1); tick(1);
        chk("nopre_hold", 32'(grant), 32'h4);
        chk("both_credit_unchanged", 32'(credit_cnt), 4);
        tick(1); tick(1); tick(1);
        chk("nopre_next_grant", 32'(grant), 32'h1);
        tick(1);
        chk("nopre_idle", 32'(grant), 0);

        // credit stall on a 6-flit packet
        wr_count = 0;
        load(1, 6, 1); push(1, 6);
        tick(0);
        chk("stall_grant", 32'(grant), 32'h2);
        tick(0); tick(0); tick(0); tick(0);
        chk("stall_credit0", 32'(credit_cnt), 0);
        chk("stall_flit_wr0", 32'(flit_wr), 0);
        tick(0); tick(0);
        chk("stall_wr_count4", 32'(wr_count), 4);
        tick(1);
        chk("stall_credit1", 32'(credit_cnt), 1);
        chk("stall_flit_wr1", 32'(flit_wr), 1);
        tick(0);
        chk("stall_one_more", 32'(wr_count), 5);
        chk("stall_flit_wr_again0", 32'(flit_wr), 0);
        tick(1); tick(0);
        chk("stall_done_grant", 32'(grant), 0);
        chk("stall_wr_count6", 32'(wr_count), 6);
        for (int k = 0; k < 5; k++) tick(1);
        chk("stall_credit_sat", 32'(credit_cnt), 4);

        // reset in the middle of a 4-flit packet
        load(3, 4, 1); push(3, 2);
        tick(0);
        chk("mid_grant", 32'(grant), 32'h8);
        tick(0); tick(0);
        reset = 1'b1;
        tick(0);
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_credit", 32'(credit_cnt), 4);
        chk("mid_rst_flit_wr", 32'(flit_wr), 0);
        reset = 1'b0;
        clear_all();
        load(1, 1, 1); load(2, 1, 1); push(1, 1); push(2, 1);
        tick(0);
        chk("mid_ptr0_grant", 32'(grant), 32'h2);
        tick(0); tick(0); tick(0); tick(0);
        chk("final_q_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
